// File: rtl/riscv_boot_pkg.sv
// Shared definitions for the IMEM boot loader.
//   state_e        : loader FSM states (3-bit encoding)
//   BYTES_PER_WORD : stream bytes packed into one IMEM word
//   HDR_BYTES      : bytes in the little-endian word-count header
//   is_busy()      : true while a load is in progress (HDR_LO..WRITE)
package riscv_boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_LO = 3'd1,
    S_HDR_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

  function automatic logic is_busy(input state_e s);
    return (s == S_HDR_LO) || (s == S_HDR_HI) || (s == S_DATA) || (s == S_WRITE);
  endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : synchronous clear of byte index and word buffer
//   load_en_i  : shift byte_i into the word on this edge
//   byte_i     : stream byte
//   word_o     : assembled word (first byte in [7:0])
//   full_o     : the next loaded byte completes the word
module boot_word_packer
  import riscv_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        load_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  bidx_q;
  logic [31:0] word_q;

  // Byte index and shift-in buffer; shifting right places the first byte in [7:0] after four loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bidx_q <= 2'd0;
      word_q <= 32'd0;
    end else if (clr_i) begin
      bidx_q <= 2'd0;
      word_q <= 32'd0;
    end else if (load_en_i) begin
      bidx_q <= bidx_q + 2'd1;
      word_q <= {byte_i, word_q[31:8]};
    end
  end

  assign word_o = word_q;
  assign full_o = (bidx_q == LAST_LANE);

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader feeding the core's IMEM write port.
// Frame: CNT_LO, CNT_HI (word count N), then 4*N little-endian word bytes.
//   clk, rst     : clock, asynchronous active-high reset
//   restart      : synchronous abort; returns to header wait, clears enb/load_err/words_loaded
//   in_data/in_valid/in_ready : byte stream handshake
//   inst_wen/inst_addr/inst_data : one-cycle IMEM write per assembled word
//   enb          : core enable, high once a load completes
//   load_err     : header count exceeded DEPTH
//   busy         : load in progress
//   words_loaded : words written since the last header
module imem_boot_loader
  import riscv_boot_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              inst_wen,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_data,
  output logic              enb,
  output logic              load_err,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int               CNT_W   = 8 * HDR_BYTES;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e             state_q;
  logic [7:0]         n_lo_q;
  logic [CNT_W-1:0]   n_q;
  logic [ADDR_W:0]    widx_q;

  logic               accept_s;
  logic [CNT_W-1:0]   n_hdr_s;
  logic [CNT_W-1:0]   widx_next_s;
  logic               pk_clr_s;
  logic               pk_load_s;
  logic               pk_full_s;
  logic [31:0]        pk_word_s;

  // in_ready is a pure decode of the state register, gated only by restart.
  assign in_ready    = ((state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_DATA)) && !restart;
  assign accept_s    = in_valid && in_ready;
  assign n_hdr_s     = {in_data, n_lo_q};
  assign widx_next_s = CNT_W'(widx_q) + ONE_C;

  // A fresh header (or an abort) discards any partial word.
  assign pk_clr_s  = restart || ((state_q == S_HDR_HI) && accept_s);
  assign pk_load_s = (state_q == S_DATA) && accept_s;

  boot_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (pk_clr_s),
    .load_en_i (pk_load_s),
    .byte_i    (in_data),
    .word_o    (pk_word_s),
    .full_o    (pk_full_s)
  );

  // Loader FSM, header count and word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_lo_q  <= 8'd0;
      n_q     <= '0;
      widx_q  <= '0;
    end else if (restart) begin
      state_q <= S_HDR_LO;
      widx_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_HDR_LO;
        S_HDR_LO: begin
          if (accept_s) begin
            n_lo_q  <= in_data;
            state_q <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (accept_s) begin
            n_q    <= n_hdr_s;
            widx_q <= '0;
            if (n_hdr_s == '0)          state_q <= S_DONE;
            else if (n_hdr_s > DEPTH_C) state_q <= S_ERR;
            else                        state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept_s && pk_full_s) state_q <= S_WRITE;
        end
        S_WRITE: begin
          widx_q <= widx_q + 1'b1;
          if (widx_next_s == n_q) state_q <= S_DONE;
          else                    state_q <= S_DATA;
        end
        S_DONE:  state_q <= S_DONE;
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write port is zeroed outside WRITE; restart suppresses a pending strobe.
  assign inst_wen     = (state_q == S_WRITE) && !restart;
  assign inst_addr    = (state_q == S_WRITE) ? widx_q[ADDR_W-1:0] : '0;
  assign inst_data    = (state_q == S_WRITE) ? pk_word_s : 32'd0;
  assign enb          = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);
  assign busy         = is_busy(state_q);
  assign words_loaded = widx_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              restart = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              inst_wen;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_data;
  logic              enb;
  logic              load_err;
  logic              busy;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .restart(restart), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .inst_wen(inst_wen), .inst_addr(inst_addr), .inst_data(inst_data),
    .enb(enb), .load_err(load_err), .busy(busy), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;

  always @(posedge clk) cyc++;

  // Observed IMEM writes and expected model
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];
  int                got_cyc[$];
  logic [31:0]       exp_data[$];
  logic [7:0]        tx_q[$];
  int                enb_rise_cyc = -1;
  logic              prev_enb = 1'b0;

  // Reference packing: first byte is least significant.
  function automatic logic [31:0] pack4(input logic [7:0] b0, b1, b2, b3);
    return 32'(b0) | (32'(b1) << 8) | (32'(b2) << 16) | (32'(b3) << 24);
  endfunction

  // Monitor: logs writes, checks ready/write exclusivity and idle write-port zeroing.
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_wen) begin
        got_addr.push_back(inst_addr);
        got_data.push_back(inst_data);
        got_cyc.push_back(cyc);
      end
      if (!restart) begin
        if (busy) begin
          total_cnt++;
          if (in_ready !== !inst_wen)
            $display("FAIL ready_vs_write @cyc %0d: in_ready=%b inst_wen=%b, required in_ready=!inst_wen", cyc, in_ready, inst_wen);
          else pass_cnt++;
        end
        if (!inst_wen) begin
          total_cnt++;
          if (inst_addr !== '0 || inst_data !== 32'd0)
            $display("FAIL idle_port_zero @cyc %0d: addr=%0d data=%h, required 0/0", cyc, inst_addr, inst_data);
          else pass_cnt++;
        end
      end
      if (enb && !prev_enb) enb_rise_cyc = cyc;
    end
    prev_enb = enb;
  end

  task automatic clear_log();
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    exp_data.delete(); tx_q.delete();
    enb_rise_cyc = -1;
  endtask

  task automatic do_reset();
    restart = 1'b0; in_valid = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_log();
  endtask

  // Offer one byte until accepted; starts and ends at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int duty);
    bit done = 1'b0;
    int n = 0;
    while (!done && n < 400) begin
      in_data  = b;
      in_valid = (int'($urandom_range(0, 99)) < duty);
      @(negedge clk);
      done = in_valid && in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      n++;
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL send_byte_timeout: byte %h not accepted, required acceptance within 400 cycles", b);
    end
  endtask

  task automatic send_all(input int duty);
    foreach (tx_q[i]) send_byte(tx_q[i], duty);
  endtask

  task automatic wait_enb(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (enb === 1'b1);
    end
    @(posedge clk);
    #1;
    total_cnt++;
    if (!seen) $display("FAIL %s_enb_timeout: enb=%b, required 1 within 40 cycles", name, enb);
    else pass_cnt++;
  endtask

  task automatic compare_writes(input string name);
    total_cnt++;
    if (got_addr.size() != exp_data.size())
      $display("FAIL %s_count: got %0d writes, required %0d", name, got_addr.size(), exp_data.size());
    else pass_cnt++;
    for (int i = 0; i < got_addr.size() && i < exp_data.size(); i++) begin
      total_cnt++;
      if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== exp_data[i])
        $display("FAIL %s_write%0d: got addr %0d data %h, required addr %0d data %h",
                 name, i, got_addr[i], got_data[i], i, exp_data[i]);
      else pass_cnt++;
    end
  endtask

  task automatic check_wl(input string name, input int req);
    total_cnt++;
    if (words_loaded !== (ADDR_W+1)'(req))
      $display("FAIL %s_words_loaded: got %0d, required %0d", name, words_loaded, req);
    else pass_cnt++;
  endtask

  task automatic load_case1();
    tx_q = '{8'h03, 8'h00, 8'h13, 8'h07, 8'hF0, 8'h00, 8'h93, 8'h07, 8'h00, 8'h01,
             8'h13, 8'h08, 8'hF0, 8'hFF};
    exp_data = '{32'h00F00713, 32'h01000793, 32'hFFF00813};
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if ({in_ready, inst_wen, inst_addr, inst_data, enb, load_err, busy, words_loaded} !== '0)
      $display("FAIL reset_outputs: ready=%b wen=%b addr=%0d data=%h enb=%b err=%b busy=%b wl=%0d, required all 0",
               in_ready, inst_wen, inst_addr, inst_data, enb, load_err, busy, words_loaded);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_idle: in_ready=%b busy=%b, required 0/0", in_ready, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL reset_hdr_lo: in_ready=%b busy=%b, required 1/1", in_ready, busy);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic(input int duty, input string name);
    do_reset();
    load_case1();
    send_all(duty);
    wait_enb(name);
    compare_writes(name);
    check_wl(name, 3);
    total_cnt++;
    if (got_cyc.size() == 0 || enb_rise_cyc != got_cyc[got_cyc.size()-1] + 1)
      $display("FAIL %s_enb_latency: enb rose at cyc %0d, required one cycle after last write", name, enb_rise_cyc);
    else pass_cnt++;
    total_cnt++;
    if (load_err !== 1'b0) $display("FAIL %s_load_err: got %b, required 0", name, load_err);
    else pass_cnt++;
    // Extra bytes in DONE must be refused.
    in_valid = 1'b1; in_data = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b0 || enb !== 1'b1)
        $display("FAIL %s_done_hold: in_ready=%b enb=%b, required 0/1", name, in_ready, enb);
      else pass_cnt++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_wl(name, 3);
  endtask

  task automatic test_zero_count();
    do_reset();
    send_byte(8'h00, 100);
    send_byte(8'h00, 100);
    @(negedge clk);
    total_cnt++;
    if (enb !== 1'b1 || load_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_enb: enb=%b load_err=%b busy=%b, required 1/0/0", enb, load_err, busy);
    else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (got_addr.size() != 0) $display("FAIL zero_writes: got %0d writes, required 0", got_addr.size());
    else pass_cnt++;
    check_wl("zero", 0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h81, 100);
    send_byte(8'h00, 100);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      total_cnt++;
      if (load_err !== 1'b1 || enb !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL overflow_hold%0d: load_err=%b enb=%b in_ready=%b, required 1/0/0", i, load_err, enb, in_ready);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL overflow_restart_ready: in_ready=%b, required 0", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1 restart = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (load_err !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL overflow_cleared: load_err=%b in_ready=%b, required 0/1", load_err, in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_depth();
    logic [7:0] b[4];
    do_reset();
    tx_q.push_back(8'(DEPTH));
    tx_q.push_back(8'(DEPTH >> 8));
    for (int w = 0; w < DEPTH; w++) begin
      for (int j = 0; j < 4; j++) begin
        b[j] = 8'($urandom);
        tx_q.push_back(b[j]);
      end
      exp_data.push_back(pack4(b[0], b[1], b[2], b[3]));
    end
    send_all(70);
    wait_enb("depth");
    compare_writes("depth");
    check_wl("depth", DEPTH);
    total_cnt++;
    if (load_err !== 1'b0) $display("FAIL depth_load_err: got %b, required 0", load_err);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    do_reset();
    // Abort in the WRITE cycle: strobe must be suppressed.
    tx_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_all(100);
    restart = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (inst_wen !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL restart_write_abort: inst_wen=%b in_ready=%b, required 0/0", inst_wen, in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1 restart = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1 || got_addr.size() != 0)
      $display("FAIL restart_after_abort: in_ready=%b writes=%0d, required 1/0", in_ready, got_addr.size());
    else pass_cnt++;
    check_wl("restart_abort", 0);
    @(posedge clk);
    #1;
    // Abort after two data bytes, then a clean one-word frame.
    tx_q = '{8'h02, 8'h00, 8'h55, 8'h66};
    send_all(100);
    restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    tx_q = '{8'h01, 8'h00, 8'hEF, 8'h02, 8'h00, 8'h01};
    exp_data = '{32'h010002EF};
    send_all(100);
    wait_enb("restart");
    compare_writes("restart");
    check_wl("restart", 1);
  endtask

  task automatic test_async_rst();
    do_reset();
    tx_q = '{8'h02, 8'h00, 8'hDE, 8'hAD};
    send_all(100);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, inst_wen, inst_addr, inst_data, enb, load_err, busy, words_loaded} !== '0)
      $display("FAIL async_rst_outputs: ready=%b busy=%b wl=%0d enb=%b, required all 0", in_ready, busy, words_loaded, enb);
    else pass_cnt++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL async_rst_idle: in_ready=%b, required 0", in_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL async_rst_hdr_lo: in_ready=%b, required 1", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    clear_log();
    load_case1();
    send_all(100);
    wait_enb("async_reload");
    compare_writes("async_reload");
    check_wl("async_reload", 3);
  endtask

  initial begin
    test_reset();
    test_basic(100, "basic");
    test_zero_count();
    test_overflow();
    test_basic(50, "backpressure");
    test_full_depth();
    test_restart();
    test_async_rst();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
